// File: rtl/uart_transceiver_p.sv
// uart_transceiver_p: parametrised full-duplex UART with parity,
// majority-vote RX, error flags and a 1-entry echo path.
module uart_transceiver_p #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic                 txd,
  input  logic [1:0]           mode,
  input  logic                 echo,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID_LO    = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] MID       = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] MID_HI    = CW'(CLKS_PER_BIT / 2 + 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA, T_PAR, T_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_BREAK
  } rx_state_t;

  tx_state_t tx_state, tx_next;
  logic [CW-1:0]        tx_cnt;
  logic [IW-1:0]        tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_pbit;
  logic                 tx_par_en;
  logic                 tx_end;
  logic                 start_req;
  logic [DATA_BITS-1:0] tx_src;

  logic                 pend_valid;
  logic [DATA_BITS-1:0] pend_data;
  logic                 echo_push;
  logic                 echo_drop;

  rx_state_t rx_state, rx_next;
  logic [1:0]           rx_sync;
  logic                 rx_s;
  logic [CW-1:0]        rx_cnt;
  logic [IW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_pbit;
  logic                 rx_par_en;
  logic                 rx_par_odd;
  logic                 s0, s1;
  logic                 vote;
  logic                 at_hi;
  logic                 rx_bend;
  logic                 rx_done;
  logic                 done_perr;
  logic                 done_ferr;
  logic                 consume;

  assign tx_ready  = (tx_state == T_IDLE) && !echo;
  assign start_req = (tx_state == T_IDLE) && (echo ? pend_valid : tx_valid);
  assign tx_src    = echo ? pend_data : tx_data;
  assign tx_end    = (tx_state == T_STOP) ? (tx_cnt == STOP_LAST)
                                          : (tx_cnt == BIT_LAST);

  // TX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= T_IDLE;
    else        tx_state <= tx_next;
  end

  // TX next-state: walk start, data, optional parity, stop
  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      T_IDLE:  if (start_req) tx_next = T_START;
      T_START: if (tx_end) tx_next = T_DATA;
      T_DATA:
        if (tx_end && tx_idx == IDX_LAST)
          tx_next = tx_par_en ? T_PAR : T_STOP;
      T_PAR:   if (tx_end) tx_next = T_STOP;
      T_STOP:  if (tx_end) tx_next = T_IDLE;
      default: tx_next = T_IDLE;
    endcase
  end

  // TX datapath: latch frame at handshake, drive registered txd
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txd       <= 1'b1;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_shift  <= '0;
      tx_pbit   <= 1'b0;
      tx_par_en <= 1'b0;
    end else if (tx_state == T_IDLE) begin
      tx_cnt <= '0;
      tx_idx <= '0;
      if (start_req) begin
        tx_shift  <= tx_src;
        tx_pbit   <= (^tx_src) ^ (mode == 2'b10);
        tx_par_en <= (mode == 2'b01) || (mode == 2'b10);
        txd       <= 1'b0;
      end else begin
        txd <= 1'b1;
      end
    end else begin
      tx_cnt <= tx_end ? '0 : tx_cnt + 1'b1;
      if (tx_end) begin
        if (tx_state == T_START) begin
          txd <= tx_shift[0];
        end else if (tx_state == T_DATA) begin
          tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
          tx_idx   <= tx_idx + 1'b1;
          if (tx_idx == IDX_LAST)
            txd <= tx_par_en ? tx_pbit : 1'b1;
          else
            txd <= tx_shift[1];
        end else begin
          txd <= 1'b1;
        end
      end
    end
  end

  assign echo_push = rx_done && echo && !done_perr && !done_ferr;
  assign echo_drop = echo_push && pend_valid;

  // Echo pending slot: filled by clean RX bytes, drained by TX start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
    end else if (!echo) begin
      pend_valid <= 1'b0;
    end else if (echo_push && !pend_valid) begin
      pend_valid <= 1'b1;
      pend_data  <= rx_shift;
    end else if (start_req) begin
      pend_valid <= 1'b0;
    end
  end

  assign rx_s    = rx_sync[1];
  assign vote    = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign at_hi   = rx_cnt == MID_HI;
  assign rx_bend = rx_cnt == BIT_LAST;
  assign consume = rx_valid && rx_ready;
  assign done_perr = rx_par_en & ((^rx_shift) ^ rx_pbit ^ rx_par_odd);
  assign done_ferr = !vote;

  // Two-flop synchronizer for the asynchronous serial input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], rxd};
  end

  // RX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= R_IDLE;
    else        rx_state <= rx_next;
  end

  // RX next-state: votes land at mid+1, completion at first stop vote
  always_comb begin
    rx_next = rx_state;
    rx_done = 1'b0;
    unique case (rx_state)
      R_IDLE:  if (!rx_s) rx_next = R_START;
      R_START:
        if (at_hi && vote) rx_next = R_IDLE;
        else if (rx_bend)  rx_next = R_DATA;
      R_DATA:
        if (rx_bend && rx_idx == IDX_LAST)
          rx_next = rx_par_en ? R_PAR : R_STOP;
      R_PAR:   if (rx_bend) rx_next = R_STOP;
      R_STOP:
        if (at_hi) begin
          rx_done = 1'b1;
          rx_next = vote ? R_IDLE : R_BREAK;
        end
      R_BREAK: if (rx_s) rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end

  // RX datapath: bit timing, majority samples, shift-in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rx_pbit    <= 1'b0;
      rx_par_en  <= 1'b0;
      rx_par_odd <= 1'b0;
      s0         <= 1'b1;
      s1         <= 1'b1;
    end else if (rx_state == R_IDLE) begin
      rx_cnt <= CW'(1);
      rx_idx <= '0;
      if (!rx_s) begin
        rx_par_en  <= (mode == 2'b01) || (mode == 2'b10);
        rx_par_odd <= (mode == 2'b10);
      end
    end else begin
      rx_cnt <= rx_bend ? '0 : rx_cnt + 1'b1;
      if (rx_cnt == MID_LO) s0 <= rx_s;
      if (rx_cnt == MID)    s1 <= rx_s;
      if (at_hi && rx_state == R_DATA)
        rx_shift <= {vote, rx_shift[DATA_BITS-1:1]};
      if (at_hi && rx_state == R_PAR)
        rx_pbit <= vote;
      if (rx_bend && rx_state == R_DATA)
        rx_idx <= rx_idx + 1'b1;
    end
  end

  // RX output register, handshake and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      if (rx_done && (!rx_valid || consume)) begin
        rx_data       <= rx_shift;
        rx_valid      <= 1'b1;
        rx_parity_err <= done_perr;
        rx_frame_err  <= done_ferr;
      end else if (consume) begin
        rx_valid      <= 1'b0;
        rx_parity_err <= 1'b0;
        rx_frame_err  <= 1'b0;
      end
      if ((rx_done && rx_valid && !consume) || echo_drop)
        rx_overrun <= 1'b1;
      else if (consume)
        rx_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_transceiver_p.sv
// tb_uart_transceiver_p: directed bench for uart_transceiver_p,
// 8-bit frames at 16 clocks per bit, plus a two-stop-bit instance.
module tb_uart_transceiver_p;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       echo = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       rx_ready = 1'b0;
  logic       txd, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_parity_err, rx_frame_err, rx_overrun;

  logic [7:0] tx2_data = 8'h00;
  logic       tx2_valid = 1'b0;
  logic       txd2, tx2_ready;
  logic [7:0] rx2_data;
  logic       rx2_valid, rx2_perr, rx2_ferr, rx2_ovr;

  int total = 0;
  int bad = 0;
  int n;
  logic capb [0:255];

  uart_transceiver_p #(
    .CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .txd(txd),
    .mode(mode), .echo(echo),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .rx_overrun(rx_overrun)
  );

  uart_transceiver_p #(
    .CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .rxd(1'b1), .txd(txd2),
    .mode(2'b00), .echo(1'b0),
    .tx_data(tx2_data), .tx_valid(tx2_valid), .tx_ready(tx2_ready),
    .rx_data(rx2_data), .rx_valid(rx2_valid), .rx_ready(1'b0),
    .rx_parity_err(rx2_perr), .rx_frame_err(rx2_ferr),
    .rx_overrun(rx2_ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input bit sel, input logic [7:0] d);
    @(negedge clk);
    if (sel) begin tx2_data = d; tx2_valid = 1'b1; end
    else     begin tx_data = d;  tx_valid = 1'b1;  end
    @(negedge clk);
    tx_valid  = 1'b0;
    tx2_valid = 1'b0;
  endtask

  task automatic cap_tx(input bit sel, output int cnt);
    cnt = 0;
    while ((sel ? tx2_ready : tx_ready) == 1'b0 && cnt < 256) begin
      capb[cnt] = sel ? txd2 : txd;
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic check_bits(input string tag, input int nbits,
                            input logic [15:0] exp);
    for (int b = 0; b < nbits; b++) begin
      int ok;
      ok = 0;
      for (int j = 0; j < C; j++)
        if (capb[b*C+j] === exp[b]) ok++;
      chk($sformatf("%s_b%0d", tag, b), ok, C);
    end
  endtask

  task automatic rx_bit(input logic v, input int spike);
    for (int j = 0; j < C; j++) begin
      rxd = (j == spike) ? ~v : v;
      @(negedge clk);
    end
  endtask

  task automatic rx_frame(input logic [7:0] d, input bit par,
                          input logic pb, input logic stp,
                          input int spike_bit);
    rx_bit(1'b0, -1);
    for (int i = 0; i < 8; i++)
      rx_bit(d[i], (i == spike_bit) ? 8 : -1);
    if (par) rx_bit(pb, -1);
    rx_bit(stp, -1);
  endtask

  task automatic take(input string tag);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk(tag, rx_valid, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_txd", txd, 1'b1);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_flags", {rx_parity_err, rx_frame_err, rx_overrun}, 3'b000);

    send(1'b0, 8'h31);
    cap_tx(1'b0, n);
    chk("tx31_ready_low", n, 160);
    check_bits("tx31", 10, 16'b0000_0010_0110_0010);

    mode = 2'b01;
    rx_frame(8'hA5, 1'b1, 1'b0, 1'b1, -1);
    chk("even_valid", rx_valid, 1'b1);
    chk("even_data", rx_data, 8'hA5);
    chk("even_perr", rx_parity_err, 1'b0);
    chk("even_ferr", rx_frame_err, 1'b0);
    take("even_take");
    rx_frame(8'hA5, 1'b1, 1'b1, 1'b1, -1);
    chk("bad_par_valid", rx_valid, 1'b1);
    chk("bad_par_perr", rx_parity_err, 1'b1);
    take("bad_par_take");
    rx_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1);
    chk("frame_ferr", rx_frame_err, 1'b1);
    chk("frame_perr", rx_parity_err, 1'b0);
    take("frame_take");
    repeat (200) @(negedge clk);
    chk("break_hold", rx_valid, 1'b0);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    rx_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1);
    chk("after_break_data", rx_data, 8'h3C);
    chk("after_break_err",
        {rx_valid, rx_parity_err, rx_frame_err}, 3'b100);
    take("after_break_take");

    mode = 2'b10;
    rx_frame(8'hA5, 1'b1, 1'b1, 1'b1, -1);
    chk("odd_perr", {rx_valid, rx_parity_err}, 2'b10);
    take("odd_take");

    mode = 2'b00;
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_valid", rx_valid, 1'b0);
    chk("glitch_flags",
        {rx_parity_err, rx_frame_err, rx_overrun}, 3'b000);
    rx_frame(8'h0F, 1'b0, 1'b0, 1'b1, 3);
    chk("spike_valid", rx_valid, 1'b1);
    chk("spike_data", rx_data, 8'h0F);
    take("spike_take");

    rx_frame(8'h11, 1'b0, 1'b0, 1'b1, -1);
    rx_frame(8'h22, 1'b0, 1'b0, 1'b1, -1);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_flag", rx_overrun, 1'b1);
    take("ovr_take");
    chk("ovr_clear", rx_overrun, 1'b0);

    echo = 1'b1;
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    fork
      begin
        rx_frame(8'h36, 1'b0, 1'b0, 1'b1, -1);
        rx_frame(8'h1E, 1'b0, 1'b0, 1'b1, -1);
      end
      begin
        int w;
        logic [9:0] got;
        logic rdy_seen;
        rdy_seen = 1'b0;
        for (int f = 0; f < 2; f++) begin
          w = 0;
          got = '0;
          while (txd !== 1'b0 && w < 2000) begin
            rdy_seen |= tx_ready;
            w++;
            @(negedge clk);
          end
          chk("echo_start", w < 2000, 1'b1);
          repeat (8) @(negedge clk);
          for (int b = 0; b < 10; b++) begin
            got[b] = txd;
            rdy_seen |= tx_ready;
            if (b < 9) repeat (C) @(negedge clk);
          end
          if (f == 0) chk("echo_36", got, 10'b10_0110_1100);
          else        chk("echo_1e", got, 10'b10_0011_1100);
        end
        chk("echo_tx_ready", rdy_seen, 1'b0);
      end
    join
    chk("echo_overrun", rx_overrun, 1'b0);
    echo = 1'b0;
    rx_ready = 1'b0;
    repeat (20) @(negedge clk);

    send(1'b1, 8'h31);
    cap_tx(1'b1, n);
    chk("stop2_ready_low", n, 176);
    check_bits("stop2", 11, 16'b0000_0110_0110_0010);

    send(1'b0, 8'hAA);
    repeat (85) @(negedge clk);
    chk("pre_rst_txd", txd, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_txd", txd, 1'b1);
    chk("mid_rst_ready", tx_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 8'h55);
    cap_tx(1'b0, n);
    chk("tx55_ready_low", n, 160);
    check_bits("tx55", 10, 16'b0000_0010_1010_1010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_transceiver_p.md
Name: uart_transceiver_p

Overview:
- Parametrised full-duplex UART transceiver. Successor to the fixed 8N1 serial transceiver.
- Adds configurable data width, stop bits and bit period, plus runtime parity mode.
- RX uses a 3-sample majority vote. Reports parity, framing and overrun errors.
- Uses valid/ready byte interfaces on both sides. An echo mode retransmits received bytes through a 1-entry pending buffer.
- Sits between the board serial pins and byte-level logic.

Parameters:
- CLKS_PER_BIT, 10416, clock cycles per bit (100 MHz / 9600 baud); legal values are 8 or more.
- DATA_BITS, 8, data bits per frame; legal values are 5..9.
- STOP_BITS, 1, stop bits generated by TX (1 or 2); RX checks only the first stop bit.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rxd  in  1  serial input, asynchronous, idle high
- txd  out  1  serial output, registered, idle high
- mode  in  2  parity select: 00 none, 01 even, 10 odd, 11 none
- echo  in  1  1 = retransmit each error-free received byte
- tx_data  in  DATA_BITS  byte to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  TX can accept a byte
- rx_data  out  DATA_BITS  last received byte
- rx_valid  out  1  rx_data holds an unconsumed byte
- rx_ready  in  1  consumer accepts rx_data
- rx_parity_err  out  1  parity mismatch on the byte in rx_data
- rx_frame_err  out  1  first stop bit sampled low on the byte in rx_data
- rx_overrun  out  1  a completed byte was dropped (sticky)

Behaviour:
- Reset (async, rst_n=0):
  - txd=1, tx_ready=1, rx_valid=0, rx_data=0, all error flags 0, echo buffer empty.
  - Both FSMs go to IDLE, counters clear.
  - Reset mid-frame aborts the frame immediately; txd returns high asynchronously.
- Frame format: start(0), data LSB-first, optional parity bit, stop bit(s) (1). Each bit lasts exactly CLKS_PER_BIT cycles.
- mode is sampled at frame start: at the TX handshake, and at RX start detection. Changes mid-frame affect only the next frame.
- Parity: even means data XOR parity = 0; odd means data XOR parity = 1.
- TX FSM (IDLE, START, DATA, PARITY, STOP):
  - Handshake is tx_valid && tx_ready in IDLE; tx_data is latched.
  - tx_ready drops and txd=0 on the next cycle.
  - PARITY state is skipped when mode is 00 or 11.
  - STOP holds txd=1 for STOP_BITS*CLKS_PER_BIT cycles, then returns to IDLE. tx_ready=1 in the same cycle as the return.
  - tx_valid held with tx_ready=1 starts back-to-back frames with no idle gap.
- RX path:
  - rxd passes through a 2-flop synchronizer (2-cycle latency).
  - RX FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE to START on synced rxd = 0.
  - Each bit value is the majority of the three synced samples at counts mid-1, mid and mid+1 of the bit, where mid = CLKS_PER_BIT/2.
  - A start bit that votes 1 is a false start: return to IDLE, no flags, no output.
  - After the first stop-bit vote, the byte completes (the completion cycle):
    - rx_data is loaded.
    - rx_valid is set.
    - rx_parity_err is loaded (0 when parity is disabled).
    - rx_frame_err is loaded.
  - If the stop vote is 0, the FSM goes to BREAK and waits for synced rxd=1 before IDLE.
  - Otherwise it returns to IDLE on the completion cycle. RX ignores the rest of the stop bit; it re-arms at mid-stop.
- RX handshake and overrun:
  - rx_valid && rx_ready clears rx_valid and both error flags, and clears rx_overrun.
  - Completion while rx_valid=1 and rx_ready=0: the new byte is dropped, rx_data and flags are kept, rx_overrun is set.
  - Completion in the same cycle as a consume: the new byte loads, rx_valid stays 1, no overrun.
- Echo (echo=1):
  - tx_ready is forced 0 and tx_valid is ignored.
  - An error-free completed byte goes into a 1-entry pending register. TX starts it from IDLE the next cycle.
  - If the pending register is full at completion, the byte is not echoed and rx_overrun is set.
  - Bytes with a parity or frame error are not echoed.
  - The RX valid/ready interface still presents every completed byte.
  - echo falling to 0 discards a pending byte; a frame already in progress finishes.

Test Plan:
- Bench setting: CLKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1 unless stated.
- TX 8N1, mode=00: send tx_data=0x31 → txd reads 0,1,0,0,0,1,1,0,0,1, each bit held 16 cycles, first start bit one cycle after handshake; tx_ready low for exactly 160 cycles.
- RX even parity, mode=01: drive 0xA5 with parity bit 0 → rx_data=0xA5, rx_valid=1, rx_parity_err=0. Repeat with parity bit 1 → rx_parity_err=1. Then a stop bit of 0 → rx_frame_err=1, and no new frame is accepted until rxd returns high.
- Glitch and majority:
  - A 5-cycle low pulse on idle rxd → no rx_valid, no flags.
  - A 1-cycle inverted spike at mid of data bit 3 of 0x0F → 0x0F still received.
- Overrun:
  - Two frames 0x11 then 0x22 with rx_ready=0 → rx_data=0x11, rx_overrun=1.
  - Assert rx_ready for one cycle → rx_valid=0, rx_overrun=0.
- Echo, and STOP_BITS=2 instance:
  - echo=1, rxd streams 0x36 then 0x1E back-to-back → txd reproduces both frames in order; tx_ready stays 0; no overrun.
  - On a STOP_BITS=2 instance, a TX frame is 11 bits long.
- Reset mid-frame: assert rst_n=0 during TX data bit 4 → txd=1 immediately, tx_ready=1. After release, 0x55 transmits correctly.
